md_ctrl: RTL

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_pkg.sv | 27 ++
 rtl/md_iter.sv | 61 ++++++
 rtl/md_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared FUNCT codes and operation descriptor for the multiply/divide unit.
package md_ctrl_pkg;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Everything the sign-fix stage needs to remember about the accepted op.
  typedef struct packed {
    logic is_div;
    logic neg_a;
    logic neg_b;
    logic b_zero;
  } op_t;

  function automatic logic is_long(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/md_iter.sv
// Radix-2 iterative datapath: shift-add multiply / restoring divide on magnitudes.
module md_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic [DATA_W-1:0] hi_raw,
  output logic [DATA_W-1:0] lo_raw
);

  logic [DATA_W:0]   acc, acc_nx, sum, rem_sh;
  logic [DATA_W-1:0] q, q_nx, m;
  logic              div_m;

  always_comb begin
    sum    = acc + {1'b0, m};
    rem_sh = {acc[DATA_W-1:0], q[DATA_W-1]};
    acc_nx = acc;
    q_nx   = q;
    if (div_m) begin
      if (rem_sh >= {1'b0, m}) begin
        acc_nx = rem_sh - {1'b0, m};
        q_nx   = {q[DATA_W-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh;
        q_nx   = {q[DATA_W-2:0], 1'b0};
      end
    end else begin
      // Product accumulates in acc and shifts down into q as multiplier bits retire.
      if (!q[0]) sum = acc;
      acc_nx = {1'b0, sum[DATA_W:1]};
      q_nx   = {sum[0], q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      div_m <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      q     <= a_mag;
      m     <= b_mag;
      div_m <= is_div;
    end else if (step) begin
      acc <= acc_nx;
      q   <= q_nx;
    end
  end

  assign hi_raw = acc[DATA_W-1:0];
  assign lo_raw = q;

endmodule

// File: rtl/md_ctrl.sv
// MIPS HI/LO multiply-divide controller: FSM, sign handling and architectural HI/LO.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(ITER) + 1;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  op_t                 op;
  logic [DATA_W-1:0]   a_raw, res_hi, res_lo, fix_hi, fix_lo;
  logic [DATA_W-1:0]   hi_raw, lo_raw, a_mag, b_mag;
  logic [2*DATA_W-1:0] prod_n;
  logic                long_op, sgn, neg_a, neg_b, accept;

  assign long_op = is_long(funct);
  assign sgn     = is_signed_op(funct);
  assign neg_a   = sgn & operand_a[DATA_W-1];
  assign neg_b   = sgn & operand_b[DATA_W-1];
  assign a_mag   = neg_a ? -operand_a : operand_a;
  assign b_mag   = neg_b ? -operand_b : operand_b;
  assign accept  = (state == IDLE) && start && long_op && !flush && !rst;

  md_iter #(.DATA_W(DATA_W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == CALC),
    .is_div ((funct == FN_DIV) || (funct == FN_DIVU)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_raw (hi_raw),
    .lo_raw (lo_raw)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = CALC;
      CALC: if (cnt == CW'(ITER - 1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign stall_req = start && long_op && (state != DONE) && !flush && !rst;
  assign done      = (state == DONE) && !flush && !rst;

  // Zero divisor bypasses sign fix so DIV and DIVU report the raw dividend alike.
  always_comb begin
    fix_hi = hi_raw;
    fix_lo = lo_raw;
    prod_n = -{hi_raw, lo_raw};
    if (op.is_div) begin
      if (op.b_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        if (op.neg_a ^ op.neg_b) fix_lo = -lo_raw;
        if (op.neg_a) fix_hi = -hi_raw;
      end
    end else if (op.neg_a ^ op.neg_b) begin
      fix_hi = prod_n[2*DATA_W-1:DATA_W];
      fix_lo = prod_n[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      a_raw  <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op     <= '{is_div: (funct == FN_DIV) || (funct == FN_DIVU),
                    neg_a: neg_a, neg_b: neg_b, b_zero: (operand_b == '0)};
        a_raw  <= operand_a;
        cnt    <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        res_hi <= fix_hi;
        res_lo <= fix_lo;
      end
      if (!flush) begin
        if (state == DONE) begin
          hi <= res_hi;
          lo <= res_lo;
        end else if (state == IDLE && start) begin
          if (funct == FN_MTHI) hi <= operand_a;
          if (funct == FN_MTLO) lo <= operand_a;
        end
      end
    end
  end

endmodule
